// File: rtl/spectrum_bar_quantizer.sv
// -----------------------------------------------------------------------------
// spectrum_bar_quantizer
//
// Turns one frame of FFT bin magnitudes into 0..8 bar heights for a display.
// A frame is captured into a shadow register on a mag_valid strobe. It is then
// quantized one bin per clock into working registers. The whole frame is
// published to the outputs in a single cycle, so the display never sees a
// half-updated frame.
//
// Optional feature: define SPECTRUM_PEAK_HOLD_EN to build per-bin peak-hold
// registers with timed decay. When it is undefined, peak_level mirrors
// bar_level.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   magnitudes   NUM_BINS x MAG_W bin magnitudes, stable while mag_valid is high
//   mag_valid    one-cycle frame strobe from the FFT stage
//   out_ready    display has consumed the current frame
//   bar_level    NUM_BINS x 4 quantized bar heights (0..8)
//   peak_level   NUM_BINS x 4 peak-hold heights (0..8)
//   frame_valid  bar_level/peak_level hold a new frame (high while in DONE)
//   busy         a frame is being processed or awaiting the display
//   drop_count   saturating count of strobes that arrived while not accepting
// -----------------------------------------------------------------------------
module spectrum_bar_quantizer #(
    parameter int NUM_BINS    = 16,
    parameter int MAG_W       = 18,
    parameter int MAG_SHIFT   = 10,
    parameter int HOLD_FRAMES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MAG_W-1:0] magnitudes [NUM_BINS],
    input  logic             mag_valid,
    input  logic             out_ready,
    output logic [3:0]       bar_level  [NUM_BINS],
    output logic [3:0]       peak_level [NUM_BINS],
    output logic             frame_valid,
    output logic             busy,
    output logic [7:0]       drop_count
);

    localparam int IDX_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

    if (NUM_BINS < 2 || HOLD_FRAMES < 1) begin : g_param_check
        $error("spectrum_bar_quantizer: NUM_BINS must be >= 2 and HOLD_FRAMES >= 1");
    end

    typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

    state_t             state, state_next;
    logic [IDX_W-1:0]   idx;
    logic [MAG_W-1:0]   shadow     [NUM_BINS];
    logic [3:0]         work_level [NUM_BINS];
    logic [3:0]         cur_level;
    logic               last_bin;
    logic               accept;
    logic               drop;

    // Level = bit position of the MSB of the shifted magnitude plus one, capped at 8.
    function automatic logic [3:0] quantize(input logic [MAG_W-1:0] mag);
        logic [MAG_W-1:0] v;
        logic [3:0]       lvl;
        v   = mag >> MAG_SHIFT;
        lvl = 4'd0;
        for (int i = 0; i < MAG_W; i++) begin
            if (v[i]) lvl = (i >= 8) ? 4'd8 : 4'(i + 1);
        end
        return lvl;
    endfunction

    assign cur_level = quantize(shadow[idx]);
    assign last_bin  = (state == PROC) && (idx == IDX_W'(NUM_BINS - 1));
    // A frame is taken from IDLE, or from DONE when the display releases the
    // previous frame in the same cycle. Any other strobe while busy is lost.
    assign accept    = mag_valid && ((state == IDLE) || ((state == DONE) && out_ready));
    assign drop      = mag_valid && ((state == PROC) || ((state == DONE) && !out_ready));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin : p_state
        // NOTE: every clocked assignment is non-blocking so all registers see pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin : p_next
        // NOTE: default assignment first, so no path through the case can infer a latch.
        state_next = state;
        unique case (state)
            IDLE:    if (mag_valid) state_next = PROC;
            PROC:    if (last_bin)  state_next = DONE;
            DONE:    if (out_ready) state_next = mag_valid ? PROC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // The outputs are loaded on the edge that enters DONE, so frame_valid can be decoded from the state.
    always_comb begin : p_out
        busy        = (state != IDLE);
        frame_valid = (state == DONE);
    end

    // ---------------- shadow capture ----------------
    // NOTE: the shadow register is pure data, qualified by the FSM, so it has no reset.
    always_ff @(posedge clk) begin : p_shadow
        if (accept) shadow <= magnitudes;
    end

    // ---------------- per-bin datapath and publish ----------------
    always_ff @(posedge clk or negedge rst_n) begin : p_datapath
        if (!rst_n) begin
            idx        <= '0;
            drop_count <= '0;
            for (int i = 0; i < NUM_BINS; i++) begin
                work_level[i] <= '0;
                bar_level[i]  <= '0;
            end
        end else begin
            if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;

            if (accept) begin
                idx <= '0;
            end else if (state == PROC) begin
                work_level[idx] <= cur_level;
                idx             <= last_bin ? '0 : idx + IDX_W'(1);
                // The last bin's level is still combinational on this edge, so bypass it in.
                if (last_bin) begin
                    for (int i = 0; i < NUM_BINS; i++)
                        bar_level[i] <= (i == int'(idx)) ? cur_level : work_level[i];
                end
            end
        end
    end

`ifdef SPECTRUM_PEAK_HOLD_EN
    localparam int HC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    logic [3:0]      peak     [NUM_BINS];
    logic [HC_W-1:0] hold_cnt [NUM_BINS];
    logic [3:0]      new_peak;
    logic [HC_W-1:0] new_hold;

    // A fresh level at or above the held peak restarts the hold. Otherwise the
    // peak drops by one step each time the hold time for that bin expires.
    always_comb begin : p_peak_next
        new_peak = peak[idx];
        new_hold = hold_cnt[idx];
        if (cur_level >= peak[idx]) begin
            new_peak = cur_level;
            new_hold = '0;
        end else if (hold_cnt[idx] == HC_W'(HOLD_FRAMES - 1)) begin
            new_peak = peak[idx] - 4'd1;
            new_hold = '0;
        end else begin
            new_hold = hold_cnt[idx] + HC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin : p_peak
        if (!rst_n) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                peak[i]       <= '0;
                hold_cnt[i]   <= '0;
                peak_level[i] <= '0;
            end
        end else if (state == PROC) begin
            peak[idx]     <= new_peak;
            hold_cnt[idx] <= new_hold;
            if (last_bin) begin
                for (int i = 0; i < NUM_BINS; i++)
                    peak_level[i] <= (i == int'(idx)) ? new_peak : peak[i];
            end
        end
    end
`else
    assign peak_level = bar_level;
`endif

endmodule

// File: tb/tb_spectrum_bar_quantizer.sv
// -----------------------------------------------------------------------------
// Self-checking bench for spectrum_bar_quantizer. It uses random frames and a
// frame-level reference model: one call of the model applies a whole frame.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_spectrum_bar_quantizer;

    localparam int NB = 16;
    localparam int MW = 18;
    localparam int MS = 10;
    localparam int HF = 4;

    typedef logic [MW-1:0] mag_arr_t [NB];

    logic       clk;
    logic       rst_n;
    mag_arr_t   magnitudes;
    logic       mag_valid;
    logic       out_ready;
    logic [3:0] bar_level  [NB];
    logic [3:0] peak_level [NB];
    logic       frame_valid;
    logic       busy;
    logic [7:0] drop_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [3:0] exp_bar  [NB];
    logic [3:0] exp_peak [NB];
    int         m_peak   [NB];
    int         m_hold   [NB];
    int         m_drops;

    spectrum_bar_quantizer #(
        .NUM_BINS(NB), .MAG_W(MW), .MAG_SHIFT(MS), .HOLD_FRAMES(HF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .magnitudes(magnitudes),
        .mag_valid(mag_valid),
        .out_ready(out_ready),
        .bar_level(bar_level),
        .peak_level(peak_level),
        .frame_valid(frame_valid),
        .busy(busy),
        .drop_count(drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [3:0] ref_level(input logic [MW-1:0] mag);
        int v, n;
        v = int'(mag) >> MS;
        n = 0;
        while (v > 0) begin
            n++;
            v = v >> 1;
        end
        return (n > 8) ? 4'd8 : 4'(n);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NB; i++) begin
            m_peak[i] = 0;
            m_hold[i] = 0;
        end
        m_drops = 0;
    endfunction

    function automatic void model_drop();
        if (m_drops < 255) m_drops++;
    endfunction

    function automatic void model_accept(input mag_arr_t m);
        for (int i = 0; i < NB; i++) begin
            int lvl;
            lvl = int'(ref_level(m[i]));
            exp_bar[i] = 4'(lvl);
`ifdef SPECTRUM_PEAK_HOLD_EN
            if (lvl >= m_peak[i]) begin
                m_peak[i] = lvl;
                m_hold[i] = 0;
            end else if (m_hold[i] == HF - 1) begin
                m_peak[i] = m_peak[i] - 1;
                m_hold[i] = 0;
            end else begin
                m_hold[i] = m_hold[i] + 1;
            end
            exp_peak[i] = 4'(m_peak[i]);
`else
            exp_peak[i] = 4'(lvl);
`endif
        end
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic rand_frame(output mag_arr_t m);
        for (int i = 0; i < NB; i++) begin
            int w;
            w    = $urandom_range(0, MW);
            m[i] = MW'($urandom & ((32'd1 << w) - 32'd1));
        end
    endtask

    // Strobes one frame, scrambles the input bus, and waits (bounded) for frame_valid.
    // lat counts clock edges from the accepting edge up to the edge that raises frame_valid.
    task automatic send_frame(input mag_arr_t m, input bit with_ready,
                              output int lat, output logic fv1, output logic busy1);
        mag_arr_t junk;
        magnitudes = m;
        mag_valid  = 1'b1;
        out_ready  = with_ready;
        @(negedge clk);
        mag_valid = 1'b0;
        out_ready = 1'b0;
        rand_frame(junk);
        magnitudes = junk;
        fv1   = frame_valid;
        busy1 = busy;
        lat   = 1;
        while (frame_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_frame();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        tests_run++;
        if (frame_valid !== 1'b0) begin tests_failed++; $display("FAIL reset frame_valid: got %b want 0", frame_valid); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset busy: got %b want 0", busy); end
        tests_run++;
        if (drop_count !== 8'd0) begin tests_failed++; $display("FAIL reset drop_count: got %0d want 0", drop_count); end
        for (int i = 0; i < NB; i++) begin
            tests_run++;
            if (bar_level[i] !== 4'd0 || peak_level[i] !== 4'd0) begin
                tests_failed++;
                $display("FAIL reset levels[%0d]: got bar %0d peak %0d want 0 0", i, bar_level[i], peak_level[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_quant_sweep();
        mag_arr_t m;
        int lat;
        logic fv1, b1;
        logic [3:0] want [5];
        want[0] = 4'd0; want[1] = 4'd0; want[2] = 4'd1; want[3] = 4'd2; want[4] = 4'd8;
        rand_frame(m);
        m[0] = 18'd0; m[1] = 18'd1023; m[2] = 18'd1024; m[3] = 18'd2048; m[4] = 18'h3FFFF;
        model_accept(m);
        send_frame(m, 1'b0, lat, fv1, b1);
        tests_run++;
        if (lat !== 17) begin tests_failed++; $display("FAIL sweep latency: got %0d want 17", lat); end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (bar_level[i] !== want[i]) begin tests_failed++; $display("FAIL sweep bar_level[%0d]: got %0d want %0d", i, bar_level[i], want[i]); end
        end
        for (int i = 0; i < NB; i++) begin
            tests_run++;
            if (bar_level[i] !== exp_bar[i]) begin tests_failed++; $display("FAIL sweep model bar[%0d]: got %0d want %0d", i, bar_level[i], exp_bar[i]); end
            tests_run++;
            if (peak_level[i] !== exp_peak[i]) begin tests_failed++; $display("FAIL sweep model peak[%0d]: got %0d want %0d", i, peak_level[i], exp_peak[i]); end
        end
        release_frame();
        tests_run++;
        if (frame_valid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL sweep release: got fv %b busy %b want 0 0", frame_valid, busy);
        end
    endtask

    task automatic test_random_frames();
        mag_arr_t m;
        int lat;
        logic fv1, b1;
        for (int f = 0; f < 6; f++) begin
            rand_frame(m);
            model_accept(m);
            send_frame(m, 1'b0, lat, fv1, b1);
            tests_run++;
            if (lat !== 17) begin tests_failed++; $display("FAIL random f%0d latency: got %0d want 17", f, lat); end
            for (int i = 0; i < NB; i++) begin
                tests_run++;
                if (bar_level[i] !== exp_bar[i]) begin tests_failed++; $display("FAIL random f%0d bar[%0d]: got %0d want %0d", f, i, bar_level[i], exp_bar[i]); end
                tests_run++;
                if (peak_level[i] !== exp_peak[i]) begin tests_failed++; $display("FAIL random f%0d peak[%0d]: got %0d want %0d", f, i, peak_level[i], exp_peak[i]); end
            end
            release_frame();
        end
    endtask

    task automatic test_back_to_back();
        mag_arr_t m1, m2;
        int lat;
        logic fv1, b1;
        rand_frame(m1);
        model_accept(m1);
        send_frame(m1, 1'b0, lat, fv1, b1);
        // Frame 1 is held in DONE; the next strobe arrives together with out_ready.
        rand_frame(m2);
        model_accept(m2);
        send_frame(m2, 1'b1, lat, fv1, b1);
        tests_run++;
        if (fv1 !== 1'b0) begin tests_failed++; $display("FAIL b2b frame_valid after accept: got %b want 0", fv1); end
        tests_run++;
        if (b1 !== 1'b1) begin tests_failed++; $display("FAIL b2b busy after accept: got %b want 1", b1); end
        tests_run++;
        if (lat !== 17) begin tests_failed++; $display("FAIL b2b latency: got %0d want 17", lat); end
        tests_run++;
        if (drop_count !== 8'(m_drops)) begin tests_failed++; $display("FAIL b2b drop_count: got %0d want %0d", drop_count, m_drops); end
        for (int i = 0; i < NB; i++) begin
            tests_run++;
            if (bar_level[i] !== exp_bar[i] || peak_level[i] !== exp_peak[i]) begin
                tests_failed++;
                $display("FAIL b2b levels[%0d]: got %0d/%0d want %0d/%0d", i, bar_level[i], peak_level[i], exp_bar[i], exp_peak[i]);
            end
        end
        release_frame();
    endtask

    task automatic test_backpressure();
        mag_arr_t m, junk;
        int lat;
        m_drops = int'(drop_count);
        rand_frame(m);
        model_accept(m);
        magnitudes = m;
        mag_valid  = 1'b1;
        @(negedge clk);
        mag_valid = 1'b0;
        rand_frame(junk);
        magnitudes = junk;
        repeat (3) @(negedge clk);
        // Strobe during PROC: dropped, must not disturb the frame in flight.
        mag_valid = 1'b1;
        @(negedge clk);
        mag_valid = 1'b0;
        model_drop();
        lat = 0;
        while (frame_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        tests_run++;
        if (frame_valid !== 1'b1) begin tests_failed++; $display("FAIL bp frame_valid: got %b want 1", frame_valid); end
        tests_run++;
        if (drop_count !== 8'(m_drops)) begin tests_failed++; $display("FAIL bp proc drop: got %0d want %0d", drop_count, m_drops); end
        // Three strobes while DONE holds without out_ready.
        for (int k = 0; k < 3; k++) begin
            rand_frame(junk);
            magnitudes = junk;
            mag_valid  = 1'b1;
            @(negedge clk);
            mag_valid = 1'b0;
            model_drop();
            @(negedge clk);
        end
        tests_run++;
        if (drop_count !== 8'(m_drops)) begin tests_failed++; $display("FAIL bp done drops: got %0d want %0d", drop_count, m_drops); end
        tests_run++;
        if (frame_valid !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL bp hold: got fv %b busy %b want 1 1", frame_valid, busy); end
        for (int i = 0; i < NB; i++) begin
            tests_run++;
            if (bar_level[i] !== exp_bar[i] || peak_level[i] !== exp_peak[i]) begin
                tests_failed++;
                $display("FAIL bp frozen[%0d]: got %0d/%0d want %0d/%0d", i, bar_level[i], peak_level[i], exp_bar[i], exp_peak[i]);
            end
        end
        for (int k = 0; k < 300; k++) begin
            mag_valid = 1'b1;
            @(negedge clk);
            mag_valid = 1'b0;
            model_drop();
            @(negedge clk);
        end
        tests_run++;
        if (drop_count !== 8'(m_drops) || m_drops != 255) begin
            tests_failed++;
            $display("FAIL bp saturate: got %0d want 255", drop_count);
        end
        release_frame();
        tests_run++;
        if (frame_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL bp release: got fv %b busy %b want 0 0", frame_valid, busy); end
    endtask

    task automatic test_mid_reset();
        mag_arr_t m, junk;
        int lat;
        logic fv1, b1;
        rand_frame(m);
        m[0] = 18'h3FFFF;
        magnitudes = m;
        mag_valid  = 1'b1;
        @(negedge clk);
        mag_valid = 1'b0;
        rand_frame(junk);
        magnitudes = junk;
        repeat (7) @(negedge clk);   // now working on bin 7
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL mid_reset busy before: got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (frame_valid !== 1'b0 || busy !== 1'b0 || drop_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL mid_reset flags: got fv %b busy %b drops %0d want 0 0 0", frame_valid, busy, drop_count);
        end
        for (int i = 0; i < NB; i++) begin
            tests_run++;
            if (bar_level[i] !== 4'd0 || peak_level[i] !== 4'd0) begin
                tests_failed++;
                $display("FAIL mid_reset levels[%0d]: got %0d/%0d want 0/0", i, bar_level[i], peak_level[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        rand_frame(m);
        model_accept(m);
        send_frame(m, 1'b0, lat, fv1, b1);
        tests_run++;
        if (lat !== 17) begin tests_failed++; $display("FAIL mid_reset latency: got %0d want 17", lat); end
        for (int i = 0; i < NB; i++) begin
            tests_run++;
            if (bar_level[i] !== exp_bar[i] || peak_level[i] !== exp_peak[i]) begin
                tests_failed++;
                $display("FAIL mid_reset frame[%0d]: got %0d/%0d want %0d/%0d", i, bar_level[i], peak_level[i], exp_bar[i], exp_peak[i]);
            end
        end
        release_frame();
    endtask

    task automatic test_peak_decay();
        mag_arr_t m;
        int lat, want;
        logic fv1, b1;
        do_reset();
        for (int f = 1; f <= 33; f++) begin
            for (int i = 0; i < NB; i++) m[i] = '0;
            if (f == 1) m[0] = 18'h3FFFF;
            model_accept(m);
            send_frame(m, 1'b0, lat, fv1, b1);
`ifdef SPECTRUM_PEAK_HOLD_EN
            want = 8 - (f - 1) / HF;
            if (want < 0) want = 0;
`else
            want = (f == 1) ? 8 : 0;
`endif
            tests_run++;
            if (peak_level[0] !== 4'(want)) begin
                tests_failed++;
                $display("FAIL decay frame %0d peak_level[0]: got %0d want %0d", f, peak_level[0], want);
            end
            for (int i = 0; i < NB; i++) begin
                tests_run++;
                if (bar_level[i] !== exp_bar[i] || peak_level[i] !== exp_peak[i]) begin
                    tests_failed++;
                    $display("FAIL decay frame %0d bin %0d: got %0d/%0d want %0d/%0d", f, i, bar_level[i], peak_level[i], exp_bar[i], exp_peak[i]);
                end
            end
            release_frame();
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        mag_valid  = 1'b0;
        out_ready  = 1'b0;
        for (int i = 0; i < NB; i++) magnitudes[i] = '0;
        model_clear();

        test_reset();
        test_quant_sweep();
        test_random_frames();
        test_back_to_back();
        test_backpressure();
        test_mid_reset();
        test_peak_decay();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spectrum_bar_quantizer.md
SPECTRUM_BAR_QUANTIZER -- requirements
Module: spectrum_bar_quantizer

Interface
REQ-001 SHALL have parameter NUM_BINS, default 16, the number of FFT magnitude bins per frame.
REQ-002 SHALL have parameter MAG_W, default 18, the magnitude width in bits.
REQ-003 SHALL have parameter MAG_SHIFT, default 10, the right-shift applied before quantization.
REQ-004 SHALL have parameter HOLD_FRAMES, default 4, the number of frames a peak is held before it decays.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port magnitudes, input, NUM_BINS x MAG_W unpacked: FFT bin magnitudes from the upstream mic/FFT stage.
REQ-008 SHALL have port mag_valid, input, 1 bit: one-cycle strobe (upstream done); magnitudes are stable in that cycle.
REQ-009 SHALL have port out_ready, input, 1 bit: the display consumer accepts the frame.
REQ-010 SHALL have port bar_level, output, NUM_BINS x 4 unpacked: quantized bar height per bin, range 0..8.
REQ-011 SHALL have port peak_level, output, NUM_BINS x 4 unpacked: peak-hold height per bin, range 0..8.
REQ-012 SHALL have port frame_valid, output, 1 bit: bar_level and peak_level hold a new frame.
REQ-013 SHALL have port busy, output, 1 bit: high in PROC and DONE.
REQ-014 SHALL have port drop_count, output, 8 bits: saturating count of rejected mag_valid strobes.

Function
REQ-015 SHALL implement FSM states IDLE, PROC and DONE.
REQ-016 IDLE: on mag_valid SHALL latch all magnitudes into a shadow register, clear bin index to 0, and go to PROC.
REQ-017 PROC: SHALL process exactly one bin per cycle (index 0..NUM_BINS-1) into working registers; after the last bin it SHALL go to DONE.
REQ-018 Quantization: v = mag >> MAG_SHIFT; level = 0 if v==0, else (MSB position of v)+1, saturated at 8.
REQ-019 On entry to DONE, SHALL copy all working levels to bar_level/peak_level in one cycle and assert frame_valid; outputs SHALL NOT change mid-frame.
REQ-020 DONE: SHALL hold frame_valid and the outputs until out_ready; on out_ready it SHALL go to IDLE and deassert frame_valid.
REQ-021 Latency: mag_valid at cycle 0 SHALL give frame_valid high at cycle NUM_BINS+1 (cycle 17 at defaults).
REQ-022 Peak update per bin: if level >= peak, peak=level and hold_cnt=0; else if hold_cnt==HOLD_FRAMES-1, peak=peak-1 and hold_cnt=0; else hold_cnt+1.
REQ-023 mag_valid in PROC, or in DONE without out_ready, SHALL be dropped and SHALL increment drop_count, saturating at 255.
REQ-024 mag_valid together with out_ready in DONE SHALL be accepted: latch the new frame and go directly to PROC (frame_valid low next cycle), with no drop.
REQ-025 The shadow register SHALL isolate processing from magnitudes changing after the strobe.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, bin index 0, and all working, peak, hold_cnt, bar_level and peak_level to 0, with frame_valid=0, busy=0 and drop_count=0.
REQ-027 Reset mid-PROC or mid-DONE SHALL discard the partial frame; the first mag_valid after release SHALL be processed normally.

Configuration
REQ-028 Macro SPECTRUM_PEAK_HOLD_EN, when defined, SHALL compile in the peak-hold logic of REQ-022.
REQ-029 Without SPECTRUM_PEAK_HOLD_EN, SHALL omit the peak and hold_cnt registers and drive peak_level equal to bar_level.

Verification
REQ-030 Quantization sweep, bin0..4 = 0, 1023, 1024, 2048, 0x3FFFF, one strobe -> bar_level = 0, 0, 1, 2, 8 and frame_valid at cycle 17.
REQ-031 Peak decay, bin0 frame1=0x3FFFF then zeros, out_ready=1, HOLD_FRAMES=4 -> peak_level[0] = 8, 8, 8, 8, 7 over frames 1-5, then reaches 0 at frame 33.
REQ-032 Backpressure, out_ready=0 and three strobes while in DONE -> outputs frozen, drop_count=3; with 300 such strobes -> drop_count=255.
REQ-033 Simultaneous accept, mag_valid with out_ready in DONE -> no drop, busy stays high, next frame_valid 17 cycles later.
REQ-034 Reset, rst_n pulsed low at PROC bin 7 -> all outputs 0 immediately; the next strobe yields a correct frame at cycle 17.
REQ-035 Macro off, REQ-031 stimulus -> peak_level equals bar_level every frame.
